// File: rtl/fb_pixel_writer.sv
// ============================================================================
//  Module  : fb_pixel_writer
//  Brief   : Read-modify-write pixel writer for a 64x64 12bpp two-pixel-per-word
//            panel frame buffer; optional full-screen clear (macro FB_CLEAR_EN).
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fb_pixel_writer #(
    parameter int NUM_COLS  = 64,
    parameter int NUM_ROWS  = 64,
    parameter int BIT_DEPTH = 4,
    parameter int ADDR_W    = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(NUM_COLS)-1:0]   in_x,
    input  logic [$clog2(NUM_ROWS)-1:0]   in_y,
    input  logic [3*BIT_DEPTH-1:0]        in_color,
    input  logic                          clr_req,
    input  logic [3*BIT_DEPTH-1:0]        clr_color,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_rd,
    input  logic [6*BIT_DEPTH-1:0]        mem_rdata,
    output logic                          mem_we,
    output logic [6*BIT_DEPTH-1:0]        mem_wdata
);

    localparam int c_PW = 3 * BIT_DEPTH;
    localparam int c_YW = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
`ifdef FB_CLEAR_EN
        ,
        S_CLR  = 2'd3
`endif
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [ADDR_W-1:0]   r_addr_q,  w_addr_d;
    logic                r_half_q,  w_half_d;
    logic [c_PW-1:0]     r_color_q, w_color_d;
    logic                r_done_q,  w_done_d;
    logic                w_clr_go;

`ifdef FB_CLEAR_EN
    logic [ADDR_W-1:0]   r_cnt_q,   w_cnt_d;

    assign w_clr_go = clr_req;
`else
    logic                w_unused;

    assign w_clr_go = 1'b0;
    assign w_unused = ^{clr_req, clr_color};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_addr_q  <= '0;
            r_half_q  <= 1'b0;
            r_color_q <= '0;
            r_done_q  <= 1'b0;
`ifdef FB_CLEAR_EN
            r_cnt_q   <= '0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_half_q  <= w_half_d;
            r_color_q <= w_color_d;
            r_done_q  <= w_done_d;
`ifdef FB_CLEAR_EN
            r_cnt_q   <= w_cnt_d;
`endif
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_half_d  = r_half_q;
        w_color_d = r_color_q;
        w_done_d  = 1'b0;
`ifdef FB_CLEAR_EN
        w_cnt_d   = r_cnt_q;
`endif
        // Gated by rst so the port reads 0 for the whole reset window.
        in_ready  = (r_state_q == S_IDLE) && !rst;
        busy      = (r_state_q != S_IDLE);
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (r_state_q)
            S_IDLE: begin
`ifdef FB_CLEAR_EN
                if (w_clr_go) begin
                    w_state_d = S_CLR;
                    w_color_d = clr_color;
                    w_cnt_d   = '0;
                end else
`endif
                if (in_valid && in_ready && !w_clr_go) begin
                    w_state_d = S_RD;
                    w_addr_d  = {in_y[c_YW-2:0], in_x};
                    w_half_d  = in_y[c_YW-1];
                    w_color_d = in_color;
                end
            end
            S_RD: begin
                mem_rd    = 1'b1;
                mem_addr  = r_addr_q;
                w_state_d = S_WR;
            end
            S_WR: begin
                // Top half lives in the upper bits; the other half passes through.
                mem_we    = 1'b1;
                mem_addr  = r_addr_q;
                mem_wdata = r_half_q ? {mem_rdata[2*c_PW-1:c_PW], r_color_q}
                                     : {r_color_q, mem_rdata[c_PW-1:0]};
                w_state_d = S_IDLE;
                w_done_d  = 1'b1;
            end
`ifdef FB_CLEAR_EN
            S_CLR: begin
                mem_we    = 1'b1;
                mem_addr  = r_cnt_q;
                mem_wdata = {r_color_q, r_color_q};
                w_cnt_d   = r_cnt_q + 1'b1;
                if (r_cnt_q == {ADDR_W{1'b1}}) begin
                    w_state_d = S_IDLE;
                    w_done_d  = 1'b1;
                end
            end
`endif
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign done = r_done_q;

endmodule

`default_nettype wire
